vdp_cpu_port: RTL and testbench

- CPU-side writer into the video frame buffer that the VDP display engine scans out.
- The CPU sees four byte registers:
  - address low
  - address high
  - data
  - control/status
- Data writes are queued with their target address in a small FIFO.
- Queued writes drain to the VRAM write port one per cycle while the memory arbiter grants a write slot.

---
 rtl/vdp_cpu_port.sv | 127 ++++++++++++
 tb/tb_vdp_cpu_port.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vdp_cpu_port.sv
// CPU register port into the VDP frame buffer.
// Data writes queue with their address and drain to VRAM on grant.
module vdp_cpu_port #(
  parameter int FIFO_DEPTH  = 4,
  parameter int LINE_STRIDE = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_reg,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  cpu_data_out,
  input  logic        vram_grant,
  output logic [15:0] vram_addr,
  output logic [7:0]  vram_data,
  output logic        vram_we,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] STRIDE_C = 16'(LINE_STRIDE);

  logic [15:0]   r_addr;
  logic          r_inc;
  logic          r_ovf;
  logic [15:0]   r_fa [FIFO_DEPTH];
  logic [7:0]    r_fd [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;

  logic        w_full;
  logic        w_empty;
  logic        w_wr;
  logic        w_rd;
  logic        w_dwr;
  logic        w_push;
  logic        w_pop;
  logic [15:0] w_step;
  logic [7:0]  w_rdata;

  assign w_full  = (r_cnt == DEPTH_C);
  assign w_empty = (r_cnt == '0);
  assign w_wr    = cpu_cs & cpu_we;
  assign w_rd    = cpu_cs & ~cpu_we;
  assign w_dwr   = w_wr & (cpu_reg == 2'd2);
  // Full is judged on pre-cycle state; a same-cycle pop never admits a push.
  assign w_push  = w_dwr & ~w_full;
  assign w_pop   = ~w_empty & vram_grant;
  assign w_step  = r_inc ? STRIDE_C : 16'd1;
  assign busy    = ~w_empty;

  always_comb begin
    w_rdata = 8'h00;
    unique case (cpu_reg)
      2'd0: w_rdata = r_addr[7:0];
      2'd1: w_rdata = r_addr[15:8];
      2'd2: w_rdata = 8'h00;
      2'd3: w_rdata = {4'b0, r_inc, r_ovf, w_empty, w_full};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= 16'h0000;
      r_inc  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_wr) begin
      unique case (cpu_reg)
        2'd0: r_addr[7:0]  <= cpu_data_in;
        2'd1: r_addr[15:8] <= cpu_data_in;
        2'd2: begin
          if (w_full) r_ovf  <= 1'b1;
          else        r_addr <= r_addr + w_step;
        end
        2'd3: r_inc <= cpu_data_in[0];
      endcase
    end else if (w_rd && cpu_reg == 2'd3) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cpu_data_out <= 8'h00;
    else if (w_rd) cpu_data_out <= w_rdata;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fa[r_wp] <= r_addr;
      r_fd[r_wp] <= cpu_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vram_addr <= 16'h0000;
      vram_data <= 8'h00;
      vram_we   <= 1'b0;
    end else begin
      vram_we <= w_pop;
      if (w_pop) begin
        vram_addr <= r_fa[r_rp];
        vram_data <= r_fd[r_rp];
      end
    end
  end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: queue-based model checked every cycle,
// plus literal expectations on register reads and VRAM write order.
module tb_vdp_cpu_port;

  localparam int DEPTH  = 4;
  localparam int STRIDE = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_cs;
  logic        cpu_we;
  logic [1:0]  cpu_reg;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic        vram_grant;
  logic [15:0] vram_addr;
  logic [7:0]  vram_data;
  logic        vram_we;
  logic        busy;

  vdp_cpu_port #(.FIFO_DEPTH(DEPTH), .LINE_STRIDE(STRIDE)) dut (
    .clk(clk),
    .reset(reset),
    .cpu_cs(cpu_cs),
    .cpu_we(cpu_we),
    .cpu_reg(cpu_reg),
    .cpu_data_in(cpu_data_in),
    .cpu_data_out(cpu_data_out),
    .vram_grant(vram_grant),
    .vram_addr(vram_addr),
    .vram_data(vram_data),
    .vram_we(vram_we),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: plain queue of {addr,data} plus register values.
  logic [23:0] m_q[$];
  logic [15:0] m_addr;
  bit          m_inc;
  bit          m_ovf;
  bit          m_valid = 0;
  bit          e_we;
  logic [15:0] e_addr;
  logic [7:0]  e_data;
  logic [7:0]  e_dout;
  logic [23:0] act_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_addr = 16'h0000;
      m_inc  = 0;
      m_ovf  = 0;
      e_we   = 0;
      e_addr = 16'h0000;
      e_data = 8'h00;
      e_dout = 8'h00;
      m_valid = 1;
    end else if (m_valid) begin
      bit full, empty;
      logic [23:0] e;
      full  = (m_q.size() == DEPTH);
      empty = (m_q.size() == 0);
      e_we  = 0;
      if (!empty && vram_grant) begin
        e = m_q.pop_front();
        e_we = 1;
        e_addr = e[23:8];
        e_data = e[7:0];
      end
      if (cpu_cs && cpu_we) begin
        case (cpu_reg)
          2'd0: m_addr[7:0]  = cpu_data_in;
          2'd1: m_addr[15:8] = cpu_data_in;
          2'd2: if (full) m_ovf = 1;
                else begin
                  m_q.push_back({m_addr, cpu_data_in});
                  m_addr = m_addr + (m_inc ? 16'(STRIDE) : 16'd1);
                end
          default: m_inc = cpu_data_in[0];
        endcase
      end else if (cpu_cs) begin
        case (cpu_reg)
          2'd0: e_dout = m_addr[7:0];
          2'd1: e_dout = m_addr[15:8];
          2'd2: e_dout = 8'h00;
          default: begin
            e_dout = {4'b0, m_inc, m_ovf, empty, full};
            m_ovf = 0;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("vram_we", vram_we, e_we);
      if (e_we) begin
        chk("vram_addr", vram_addr, e_addr);
        chk("vram_data", vram_data, e_data);
      end
      chk("busy", busy, m_q.size() != 0);
      chk("cpu_data_out", cpu_data_out, e_dout);
      if (vram_we) act_q.push_back({vram_addr, vram_data});
    end
  end

  task automatic wr(input logic [1:0] r, input logic [7:0] d);
    cpu_cs = 1; cpu_we = 1; cpu_reg = r; cpu_data_in = d;
    @(negedge clk);
    cpu_cs = 0; cpu_we = 0;
  endtask

  task automatic rd(input logic [1:0] r, input logic [7:0] exp,
                    input string nm);
    cpu_cs = 1; cpu_we = 0; cpu_reg = r;
    @(negedge clk);
    cpu_cs = 0;
    chk(nm, cpu_data_out, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_w(input int i, input logic [15:0] a,
                       input logic [7:0] d);
    if (i < act_q.size()) chk("write", act_q[i], {a, d});
    else chk("write_missing", act_q.size(), i + 1);
  endtask

  initial begin
    reset = 1; cpu_cs = 0; cpu_we = 0; cpu_reg = 0;
    cpu_data_in = 0; vram_grant = 0;
    idle(2);
    reset = 0;
    rd(2'd3, 8'h02, "rst_status");
    rd(2'd0, 8'h00, "rst_addr_lo");
    rd(2'd1, 8'h00, "rst_addr_hi");
    chk("rst_no_write", act_q.size(), 0);

    vram_grant = 1;
    wr(2'd1, 8'h12); wr(2'd0, 8'h34);
    wr(2'd2, 8'hAB); wr(2'd2, 8'hCD);
    idle(4);
    chk("basic_count", act_q.size(), 2);
    chk_w(0, 16'h1234, 8'hAB);
    chk_w(1, 16'h1235, 8'hCD);
    rd(2'd0, 8'h36, "basic_addr_lo");
    act_q.delete();

    wr(2'd3, 8'h01); wr(2'd1, 8'h01); wr(2'd0, 8'h00);
    wr(2'd2, 8'h01); wr(2'd2, 8'h02); wr(2'd2, 8'h03);
    idle(4);
    chk_w(0, 16'h0100, 8'h01);
    chk_w(1, 16'h0180, 8'h02);
    chk_w(2, 16'h0200, 8'h03);
    rd(2'd3, 8'h0A, "line_status");
    wr(2'd3, 8'h00);
    act_q.delete();

    wr(2'd1, 8'hFF); wr(2'd0, 8'hFF);
    wr(2'd2, 8'h11); wr(2'd2, 8'h22);
    idle(4);
    chk_w(0, 16'hFFFF, 8'h11);
    chk_w(1, 16'h0000, 8'h22);
    act_q.delete();

    vram_grant = 0;
    for (int i = 0; i < 5; i++) wr(2'd2, 8'(8'h51 + i));
    rd(2'd3, 8'h05, "ovf_status");
    rd(2'd3, 8'h01, "ovf_cleared");
    chk("hold_no_write", act_q.size(), 0);
    chk("hold_busy", busy, 1);
    vram_grant = 1;
    idle(8);
    chk("drain_count", act_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_w(i, 16'(16'h0001 + i), 8'(8'h51 + i));
    chk("drain_busy", busy, 0);
    act_q.delete();

    vram_grant = 0;
    wr(2'd2, 8'h61); wr(2'd2, 8'h62); wr(2'd2, 8'h63);
    reset = 1;
    idle(1);
    reset = 0; vram_grant = 1;
    idle(4);
    chk("rst_discard", act_q.size(), 0);
    rd(2'd3, 8'h02, "rst2_status");
    rd(2'd0, 8'h00, "rst2_addr_lo");
    rd(2'd1, 8'h00, "rst2_addr_hi");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
